return_stack: RTL and testbench

Hardware return-address stack for the pipelined 8-bit core. It sits beside the fetch stage. On a call it captures the return PC, meaning the fetch-stage PC plus one. On a return it supplies the target that the PC-select mux loads when `pc_src` = 2'b10. The block holds up to DEPTH 12-bit addresses in a LIFO and reports occupancy. It also keeps sticky overflow and underflow flags so the controller and testbench can detect call-depth errors without stalling the pipeline.

---
 rtl/return_stack.sv | 120 ++++++++++++
 tb/tb_return_stack.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Return-address stack for the pipelined 8-bit core.
// It pushes the return PC on a call and pops it on a return.
// It also reports occupancy and keeps sticky overflow and underflow flags.
module return_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,              // power of two, at least 2
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,         // synchronous, active low
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] top,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;

    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic             ovf_set;
    logic             unf_set;
    logic [PTR_W:0]   top_idx;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == (PTR_W+1)'(DEPTH));
    // Index of the current top entry; only meaningful when not empty.
    assign top_idx  = count_reg - (PTR_W+1)'(1);

    // Decode push/pop into a memory write, a count update and flag set requests.
    always_comb begin
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_addr    = count_reg[PTR_W-1:0];
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    count_next = count_reg + (PTR_W+1)'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    count_next = top_idx;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    // Nothing to replace: the push lands in slot 0, but the pop still underflowed.
                    wr_addr    = '0;
                    count_next = (PTR_W+1)'(1);
                    unf_set    = 1'b1;
                end else begin
                    // Return followed by call in one cycle: overwrite the top in place.
                    wr_addr = top_idx[PTR_W-1:0];
                end
            end
            default: ;
        endcase
        // A new error on the same edge beats a clear request.
        overflow_next  = ovf_set | (overflow_reg  & ~clear_flags);
        underflow_next = unf_set | (underflow_reg & ~clear_flags);
    end

    // Occupancy counter and sticky flags; reset wins over every other request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Entry storage; contents survive reset and are simply made unreachable.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_reg[wr_addr] <= push_data;
        end
    end

    // Top of stack reads combinationally so a return can use it on the popping edge.
    always_comb begin
        top = '0;
        if (!is_empty) begin
            top = mem_reg[top_idx[PTR_W-1:0]];
        end
    end

    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios plus a randomised back-to-back run.
module tb_return_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        clear_flags = 1'b0;
    logic [11:0] push_data = '0;
    logic [11:0] top;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected top values for upcoming pop cycles.
    logic [11:0] exp_q[$];

    // Reference stack for the randomised run (index 0 = bottom).
    logic [11:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;

    return_stack #(.WIDTH(12), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_data  (push_data),
        .clear_flags(clear_flags),
        .top        (top),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Present one request after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic pu, input logic po, input logic [11:0] d, input logic cf);
        @(negedge clk);
        push        = pu;
        pop         = po;
        push_data   = d;
        clear_flags = cf;
        #1;
    endtask

    // Let the rising edge take the request, then release the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("txn rst=%0b push=%0b pop=%0b clr=%0b data=%03h -> count=%0d top=%03h ovf=%0b unf=%0b",
                 rst, push, pop, clear_flags, push_data, count, top, overflow, underflow);
        push        = 1'b0;
        pop         = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (count !== 4'd0)     begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%0b want=1", empty); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%0b want=0", full); end
        total++; if (top !== 12'h000)    begin bad++; $display("FAIL reset_top got=%03h want=000", top); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_unf got=%0b want=0", underflow); end
        drive(1'b0, 1'b1, 12'h000, 1'b0);
        tick();
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_pop_unf got=%0b want=1", underflow); end
        total++; if (count !== 4'd0)     begin bad++; $display("FAIL empty_pop_count got=%0d want=0", count); end
        drive(1'b0, 1'b0, 12'h000, 1'b1);
        tick();
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL clear_unf got=%0b want=0", underflow); end
    endtask

    task automatic fill();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 12'(i), 1'b0);
            exp_q.push_front(12'(i));
            tick();
            total++; if (top !== 12'(i)) begin bad++; $display("FAIL fill_top got=%03h want=%03h", top, 12'(i)); end
        end
    endtask

    task automatic test_fill_drain();
        logic [11:0] e;
        fill();
        total++; if (full !== 1'b1)   begin bad++; $display("FAIL fill_full got=%0b want=1", full); end
        total++; if (count !== 4'd8)  begin bad++; $display("FAIL fill_count got=%0d want=8", count); end
        total++; if (top !== 12'h008) begin bad++; $display("FAIL fill_top8 got=%03h want=008", top); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 12'h000, 1'b0);
            e = exp_q.pop_front();
            total++; if (top !== e) begin bad++; $display("FAIL drain_top got=%03h want=%03h", top, e); end
            tick();
        end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL drain_empty got=%0b want=1", empty); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL drain_ovf got=%0b want=0", overflow); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL drain_unf got=%0b want=0", underflow); end
    endtask

    task automatic test_overflow();
        fill();
        drive(1'b1, 1'b0, 12'hABC, 1'b0);
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
        total++; if (count !== 4'd8)    begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
        total++; if (top !== 12'h008)   begin bad++; $display("FAIL ovf_top got=%03h want=008", top); end
        drive(1'b0, 1'b1, 12'h000, 1'b0);
        tick();
        total++; if (top !== 12'h007)   begin bad++; $display("FAIL ovf_pop_top got=%03h want=007", top); end
    endtask

    task automatic test_flag_clear();
        // overflow is still set from the previous scenario; count is 7.
        drive(1'b0, 1'b0, 12'h000, 1'b1);
        tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf got=%0b want=0", overflow); end
        drive(1'b1, 1'b0, 12'h008, 1'b0);
        tick();
        total++; if (full !== 1'b1)     begin bad++; $display("FAIL refill_full got=%0b want=1", full); end
        drive(1'b1, 1'b0, 12'hDEF, 1'b1);
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_beats_clear got=%0b want=1", overflow); end
        total++; if (top !== 12'h008)   begin bad++; $display("FAIL set_clear_top got=%03h want=008", top); end
        // Replace-top while full must not raise overflow.
        drive(1'b0, 1'b0, 12'h000, 1'b1);
        tick();
        drive(1'b1, 1'b1, 12'h321, 1'b0);
        tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_swap_ovf got=%0b want=0", overflow); end
        total++; if (top !== 12'h321)   begin bad++; $display("FAIL full_swap_top got=%03h want=321", top); end
        total++; if (count !== 4'd8)    begin bad++; $display("FAIL full_swap_count got=%0d want=8", count); end
    endtask

    task automatic test_push_pop();
        do_reset();
        drive(1'b1, 1'b0, 12'h010, 1'b0); tick();
        drive(1'b1, 1'b0, 12'h020, 1'b0); tick();
        drive(1'b1, 1'b0, 12'h030, 1'b0); tick();
        drive(1'b1, 1'b1, 12'h555, 1'b0);
        total++; if (top !== 12'h030)    begin bad++; $display("FAIL swap_pre_top got=%03h want=030", top); end
        tick();
        total++; if (count !== 4'd3)     begin bad++; $display("FAIL swap_count got=%0d want=3", count); end
        total++; if (top !== 12'h555)    begin bad++; $display("FAIL swap_top got=%03h want=555", top); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL swap_unf got=%0b want=0", underflow); end
        drive(1'b0, 1'b1, 12'h000, 1'b0); tick();
        total++; if (top !== 12'h020)    begin bad++; $display("FAIL swap_below got=%03h want=020", top); end
        do_reset();
        drive(1'b1, 1'b1, 12'h555, 1'b0); tick();
        total++; if (count !== 4'd1)     begin bad++; $display("FAIL swap0_count got=%0d want=1", count); end
        total++; if (top !== 12'h555)    begin bad++; $display("FAIL swap0_top got=%03h want=555", top); end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL swap0_unf got=%0b want=1", underflow); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 1'b0, 12'h100, 1'b0); tick();
        drive(1'b1, 1'b0, 12'h200, 1'b0); tick();
        drive(1'b1, 1'b0, 12'h300, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if (count !== 4'd0)     begin bad++; $display("FAIL midrst_count got=%0d want=0", count); end
        total++; if (top !== 12'h000)    begin bad++; $display("FAIL midrst_top got=%03h want=000", top); end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL midrst_empty got=%0b want=1", empty); end
        drive(1'b0, 1'b1, 12'h000, 1'b0); tick();
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL midrst_pop_unf got=%0b want=1", underflow); end
    endtask

    task automatic test_back_to_back();
        logic        pu, po, cf, so, su;
        logic [11:0] d;
        logic [11:0] e;
        int          n;
        do_reset();
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int c = 0; c < 300; c++) begin
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            cf = ($urandom_range(0, 99) < 10);
            d  = 12'($urandom());
            drive(pu, po, d, cf);
            n  = m_stk.size();
            if (po) begin
                exp_q.push_back(n > 0 ? m_stk[n-1] : 12'h000);
                e = exp_q.pop_front();
                total++; if (top !== e) begin bad++; $display("FAIL b2b_pop_top cyc=%0d got=%03h want=%03h", c, top, e); end
            end
            so = 1'b0;
            su = 1'b0;
            if (pu && po) begin
                if (n > 0) m_stk[n-1] = d;
                else begin m_stk.push_back(d); su = 1'b1; end
            end else if (pu) begin
                if (n < 8) m_stk.push_back(d);
                else so = 1'b1;
            end else if (po) begin
                if (n > 0) void'(m_stk.pop_back());
                else su = 1'b1;
            end
            m_ovf = so | (m_ovf & ~cf);
            m_unf = su | (m_unf & ~cf);
            tick();
            n = m_stk.size();
            total++; if (count !== 4'(n)) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d want=%0d", c, count, n); end
            total++; if ({overflow, underflow} !== {m_ovf, m_unf})
                begin bad++; $display("FAIL b2b_flags cyc=%0d got=%b%b want=%b%b", c, overflow, underflow, m_ovf, m_unf); end
            total++; if (top !== (n > 0 ? m_stk[n-1] : 12'h000))
                begin bad++; $display("FAIL b2b_top cyc=%0d got=%03h want=%03h", c, top, (n > 0 ? m_stk[n-1] : 12'h000)); end
            total++; if ({empty, full} !== {n == 0, n == 8})
                begin bad++; $display("FAIL b2b_status cyc=%0d got=%b%b want=%b%b", c, empty, full, n == 0, n == 8); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_flag_clear();
        test_push_pop();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
